multicycle_ctrl: RTL

Parametrised multicycle control unit for the MIPS-subset datapath. It replaces the fixed three-state fetch and ADD/SUB/AND-only decode of the previous control unit. It adds a configurable memory wait-state count, I-type, load/store, branch and jump sequencing, and a precise exception path for illegal instructions and arithmetic overflow. It sits beside the datapath and drives every mux select and write enable from a single Moore-style state register.

---
 rtl/ctrl_pkg.sv | 116 +++++++++++
 rtl/mem_wait_counter.sv | 30 +++
 rtl/multicycle_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multicycle control unit.
// Holds the FSM state enum, ALU-op / opcode / funct constants, the select
// encodings driven onto the datapath, and the bundle of registered outputs.
package ctrl_pkg;

    typedef enum logic [3:0] {
        SP_INIT,
        FETCH,
        IR_LOAD,
        DECODE,
        EXEC_R,
        WB_R,
        EXEC_I,
        WB_I,
        ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        BRANCH,
        JUMP,
        JR,
        EXC
    } state_t;

    // ALU operation codes
    localparam logic [2:0] ALU_LOAD = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_INC  = 3'b100;
    localparam logic [2:0] ALU_NOT  = 3'b101;
    localparam logic [2:0] ALU_XOR  = 3'b110;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_JR  = 6'b001000;

    // Memory address select
    localparam logic [1:0] IORD_PC     = 2'b00;
    localparam logic [1:0] IORD_ALUOUT = 2'b01;
    localparam logic [1:0] IORD_EXC    = 2'b10;

    // PC source select (11 is the exception vector, parameterised in the top)
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Register-file write data select
    localparam logic [2:0] M2R_ALUOUT  = 3'b000;
    localparam logic [2:0] M2R_MDR     = 3'b001;
    localparam logic [2:0] M2R_SP_INIT = 3'b111;

    // Register-file destination select
    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_SP = 2'b10;
    localparam logic [1:0] RDST_RD = 2'b11;

    // Exception cause
    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;

    // Outputs that are a straight decode of the state and therefore registered
    typedef struct packed {
        logic [1:0] i_or_d;
        logic [1:0] pc_source;
        logic       ir_write;
        logic       pc_write;
        logic       memory_write;
        logic       reg_write;
        logic       a_b_write;
        logic       alu_out_write;
        logic       epc_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [2:0] mem_to_reg;
        logic [1:0] reg_dist_ctrl;
    } ctrl_out_t;

    // ALU operation requested by an arithmetic R-type funct
    function automatic logic [2:0] funct_to_alu_op(input logic [5:0] f);
        logic [2:0] op;
        op = ALU_ADD;
        case (f)
            FUNCT_ADD: op = ALU_ADD;
            FUNCT_SUB: op = ALU_SUB;
            FUNCT_AND: op = ALU_AND;
            default:   op = ALU_ADD;
        endcase
        return op;
    endfunction

    // R-type functs whose result can overflow (AND never does)
    function automatic logic funct_can_overflow(input logic [5:0] f);
        return (f == FUNCT_ADD) || (f == FUNCT_SUB);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: load/decrement counter that times memory wait states.
// Loaded with MEM_WAIT-1 on entry to a memory-read state; done is high in the
// final cycle of the wait, so a one-cycle memory is done immediately.
module mem_wait_counter #(
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = $clog2(MEM_WAIT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic done
);

    logic [CNT_W-1:0] count_reg;

    // Load takes priority; decrement saturates at zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= CNT_W'(MEM_WAIT - 1);
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style control unit for the multicycle MIPS datapath.
// Sequences fetch (with MEM_WAIT wait states), decode, R/I-type execute,
// load/store, branch, jump, jump-register and a precise exception path.
// Optional feature macro: CTRL_OVERFLOW_EXC_EN -- when defined, signed
// overflow in ADD/SUB/ADDI traps to EXC (cause 10) instead of writing back.
module multicycle_ctrl #(
    parameter int         MEM_WAIT       = 1,
    parameter logic [1:0] EXC_VECTOR_SEL = 2'b11
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic [1:0] i_or_d,
    output logic [1:0] pc_source,
    output logic       ir_write,
    output logic       pc_write,
    output logic       memory_write,
    output logic       reg_write,
    output logic       a_b_write,
    output logic       alu_out_write,
    output logic       mdr_write,
    output logic       epc_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [2:0] mem_to_reg,
    output logic [1:0] reg_dist_ctrl,
    output logic [1:0] exc_cause
);

    import ctrl_pkg::*;

    localparam int CNT_W = $clog2(MEM_WAIT + 1);

    state_t     state_reg, state_next;
    logic       started_reg;
    ctrl_out_t  out_reg, out_next;
    logic [1:0] exc_cause_reg, exc_cause_next;
    logic       branch_beq_reg, branch_beq_next;
    logic       wait_load, wait_dec, wait_done;
    logic       ovf_trap;

`ifdef CTRL_OVERFLOW_EXC_EN
    assign ovf_trap = overflow;
`else
    logic unused_overflow;
    assign unused_overflow = overflow;
    assign ovf_trap        = 1'b0;
`endif

    // Shared wait-state timer for FETCH and MEM_RD
    mem_wait_counter #(
        .MEM_WAIT (MEM_WAIT),
        .CNT_W    (CNT_W)
    ) u_wait (
        .clock (clock),
        .reset (reset),
        .load  (wait_load),
        .dec   (wait_dec),
        .done  (wait_done)
    );

    // Arm the timer whenever a memory-read state is freshly entered
    always_comb begin
        wait_load = (state_next != state_reg) &&
                    ((state_next == FETCH) || (state_next == MEM_RD));
        wait_dec  = (state_reg == FETCH) || (state_reg == MEM_RD);
    end

    // Next-state, exception-cause and branch-kind selection
    always_comb begin
        state_next      = state_reg;
        exc_cause_next  = exc_cause_reg;
        branch_beq_next = branch_beq_reg;
        if (!started_reg) begin
            // first cycle after reset release presents SP_INIT
            state_next = SP_INIT;
        end else begin
            case (state_reg)
                SP_INIT: state_next = FETCH;
                FETCH:   if (wait_done) state_next = IR_LOAD;
                IR_LOAD: state_next = DECODE;
                DECODE: begin
                    branch_beq_next = (op_code == OP_BEQ);
                    case (op_code)
                        OP_RTYPE: begin
                            if ((funct == FUNCT_ADD) || (funct == FUNCT_SUB) ||
                                (funct == FUNCT_AND)) begin
                                state_next = EXEC_R;
                            end else if (funct == FUNCT_JR) begin
                                state_next = JR;
                            end else begin
                                state_next     = EXC;
                                exc_cause_next = CAUSE_ILLEGAL;
                            end
                        end
                        OP_ADDI:        state_next = EXEC_I;
                        OP_LW, OP_SW:   state_next = ADDR;
                        OP_BEQ, OP_BNE: state_next = BRANCH;
                        OP_J:           state_next = JUMP;
                        default: begin
                            state_next     = EXC;
                            exc_cause_next = CAUSE_ILLEGAL;
                        end
                    endcase
                end
                EXEC_R: begin
                    if (ovf_trap && funct_can_overflow(funct)) begin
                        state_next     = EXC;
                        exc_cause_next = CAUSE_OVERFLOW;
                    end else begin
                        state_next = WB_R;
                    end
                end
                EXEC_I: begin
                    if (ovf_trap) begin
                        state_next     = EXC;
                        exc_cause_next = CAUSE_OVERFLOW;
                    end else begin
                        state_next = WB_I;
                    end
                end
                ADDR:    state_next = (op_code == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD:  if (wait_done) state_next = MEM_WB;
                WB_R, WB_I, MEM_WB, MEM_WR, BRANCH, JUMP, JR, EXC:
                         state_next = FETCH;
                default: state_next = SP_INIT;
            endcase
        end
    end

    // Output decode of the upcoming state, so outputs register alongside it
    always_comb begin
        out_next = '0;
        case (state_next)
            SP_INIT: begin
                out_next.reg_write     = 1'b1;
                out_next.mem_to_reg    = M2R_SP_INIT;
                out_next.reg_dist_ctrl = RDST_SP;
            end
            FETCH: begin
                out_next.i_or_d = IORD_PC;
            end
            IR_LOAD: begin
                out_next.ir_write  = 1'b1;
                out_next.pc_write  = 1'b1;
                out_next.alu_src_a = 1'b0;
                out_next.alu_src_b = SRCB_FOUR;
                out_next.alu_op    = ALU_ADD;
            end
            DECODE: begin
                out_next.a_b_write     = 1'b1;
                out_next.alu_out_write = 1'b1;
                out_next.alu_src_b     = SRCB_IMM_SH2;
                out_next.alu_op        = ALU_ADD;
            end
            EXEC_R: begin
                out_next.alu_src_a     = 1'b1;
                out_next.alu_src_b     = SRCB_B;
                out_next.alu_op        = funct_to_alu_op(funct);
                out_next.alu_out_write = 1'b1;
            end
            WB_R: begin
                out_next.reg_write     = 1'b1;
                out_next.reg_dist_ctrl = RDST_RD;
            end
            EXEC_I, ADDR: begin
                out_next.alu_src_a     = 1'b1;
                out_next.alu_src_b     = SRCB_IMM;
                out_next.alu_op        = ALU_ADD;
                out_next.alu_out_write = 1'b1;
            end
            WB_I: begin
                out_next.reg_write     = 1'b1;
                out_next.reg_dist_ctrl = RDST_RT;
            end
            MEM_RD: begin
                out_next.i_or_d = IORD_ALUOUT;
            end
            MEM_WB: begin
                out_next.reg_write     = 1'b1;
                out_next.mem_to_reg    = M2R_MDR;
                out_next.reg_dist_ctrl = RDST_RT;
            end
            MEM_WR: begin
                out_next.i_or_d       = IORD_ALUOUT;
                out_next.memory_write = 1'b1;
            end
            BRANCH: begin
                // pc_write here depends on the live zero flag, resolved below
                out_next.alu_src_a = 1'b1;
                out_next.alu_src_b = SRCB_B;
                out_next.alu_op    = ALU_SUB;
                out_next.pc_source = PCSRC_ALUOUT;
            end
            JUMP: begin
                out_next.pc_source = PCSRC_JUMP;
                out_next.pc_write  = 1'b1;
            end
            JR: begin
                out_next.alu_src_a = 1'b1;
                out_next.alu_op    = ALU_LOAD;
                out_next.pc_source = PCSRC_ALU;
                out_next.pc_write  = 1'b1;
            end
            EXC: begin
                out_next.epc_write = 1'b1;
                out_next.alu_src_a = 1'b0;
                out_next.alu_src_b = SRCB_FOUR;
                out_next.alu_op    = ALU_SUB;
                out_next.pc_source = EXC_VECTOR_SEL;
                out_next.pc_write  = 1'b1;
            end
            default: out_next = '0;
        endcase
    end

    // State register with registered outputs; reset clears everything at once
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= SP_INIT;
            started_reg    <= 1'b0;
            out_reg        <= '0;
            exc_cause_reg  <= CAUSE_NONE;
            branch_beq_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            started_reg    <= 1'b1;
            out_reg        <= out_next;
            exc_cause_reg  <= exc_cause_next;
            branch_beq_reg <= branch_beq_next;
        end
    end

    // Conditional PC update and MDR capture follow live flags in their cycle
    logic branch_taken;
    assign branch_taken = (state_reg == BRANCH) && (branch_beq_reg ? zero : !zero);

    assign i_or_d        = out_reg.i_or_d;
    assign pc_source     = out_reg.pc_source;
    assign ir_write      = out_reg.ir_write;
    assign pc_write      = out_reg.pc_write | branch_taken;
    assign memory_write  = out_reg.memory_write;
    assign reg_write     = out_reg.reg_write;
    assign a_b_write     = out_reg.a_b_write;
    assign alu_out_write = out_reg.alu_out_write;
    assign mdr_write     = (state_reg == MEM_RD) && wait_done;
    assign epc_write     = out_reg.epc_write;
    assign alu_src_a     = out_reg.alu_src_a;
    assign alu_src_b     = out_reg.alu_src_b;
    assign alu_op        = out_reg.alu_op;
    assign mem_to_reg    = out_reg.mem_to_reg;
    assign reg_dist_ctrl = out_reg.reg_dist_ctrl;
    assign exc_cause     = exc_cause_reg;

endmodule
